pll_seq: RTL

Power-up and lock sequencer that sits directly upstream of the alta_pllx PLL wrapper. It drives the PLL's `pllen`, `resetn` and `clkoutNen` inputs and watches its asynchronous `lock` output. It retries on lock timeout and releases a synchronous system reset to downstream logic only after lock has been stable for a programmable time. It runs on the free-running board oscillator, which is the same clock that feeds the PLL's `clkin`.

---
 rtl/pll_seq.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/pll_seq.sv
// pll_seq: power-up and lock sequencer for the alta_pllx PLL wrapper.
//
// Raises pllen, holds the PLL in reset for RST_CYCLES, then waits for a
// lock that has been stable for STABLE_CYCLES. Failed attempts time out
// after LOCK_TIMEOUT cycles and retry until MAX_RETRY is exceeded. After
// lock is accepted, the clock outputs are enabled and the downstream
// system reset is released SYSRST_CYCLES later. A loss of lock while the
// clocks are enabled restarts the sequence without counting as a retry.
//
// Ports:
//   clkin      in   oscillator clock (also the PLL reference clock)
//   rst        in   asynchronous active-high reset
//   req        in   level request to run the PLL; low shuts it down
//   lock       in   PLL lock, asynchronous to clkin
//   pllen      out  PLL enable
//   resetn     out  PLL active-low reset
//   clkout_en  out  PLL clock output enables, bit i = output i
//   sys_rstn   out  active-low synchronous reset for downstream logic
//   ready      out  high while running with a stable lock
//   fail       out  high once the retry budget is exhausted
//   retry_cnt  out  failed attempts in this request, saturating at 3
module pll_seq #(
    parameter int         RST_CYCLES    = 8,
    parameter int         LOCK_TIMEOUT  = 4096,
    parameter int         STABLE_CYCLES = 64,
    parameter int         SYSRST_CYCLES = 16,
    parameter int         MAX_RETRY     = 3,
    parameter logic [3:0] CLKEN_MASK    = 4'b0011
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       req,
    input  logic       lock,
    output logic       pllen,
    output logic       resetn,
    output logic [3:0] clkout_en,
    output logic       sys_rstn,
    output logic       ready,
    output logic       fail,
    output logic [1:0] retry_cnt
);

    localparam int MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CD  = (STABLE_CYCLES > SYSRST_CYCLES) ? STABLE_CYCLES : SYSRST_CYCLES;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam int STAB_W  = $clog2(STABLE_CYCLES) + 1;

    localparam logic [CNT_W-1:0]  RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  SYS_LAST  = CNT_W'(SYSRST_CYCLES - 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(STABLE_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PWRUP,
        S_WAIT_LOCK,
        S_ENABLE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [STAB_W-1:0]   stab_reg, stab_next;
    logic [1:0]          retry_reg, retry_next;
    logic [2:0]          retry_inc;
    logic                lock_meta_reg, lock_s_reg;
    logic                stab_hit;

    logic                pllen_next, resetn_next, sys_rstn_next, ready_next, fail_next;
    logic [3:0]          clkout_en_next;

    // stab_hit means the stable count reaches STABLE_CYCLES on this edge,
    // so ENABLE is entered exactly STABLE_CYCLES edges after lock_s rises.
    assign stab_hit = lock_s_reg && (stab_reg >= STAB_LAST);

    always_comb begin
        state_next = state_reg;
        retry_next = retry_reg;
        retry_inc  = {1'b0, retry_reg} + 3'd1;

        if (!req) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    state_next = S_PWRUP;
                    retry_next = 2'd0;
                end
                S_PWRUP: begin
                    if (cnt_reg == RST_LAST) state_next = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    // A lock that becomes stable on the timeout cycle is accepted.
                    if (stab_hit) begin
                        state_next = S_ENABLE;
                    end else if (cnt_reg == TO_LAST) begin
                        retry_next = (retry_inc > 3'd3) ? 2'd3 : retry_inc[1:0];
                        state_next = (int'(retry_inc) > MAX_RETRY) ? S_FAIL : S_PWRUP;
                    end
                end
                S_ENABLE: begin
                    if (!lock_s_reg)             state_next = S_PWRUP;
                    else if (cnt_reg == SYS_LAST) state_next = S_RUN;
                end
                S_RUN: begin
                    if (!lock_s_reg) state_next = S_PWRUP;
                end
                S_FAIL: begin
                    state_next = S_FAIL;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end

        // Cycle counter restarts on every state change and saturates.
        if (state_next != state_reg)
            cnt_next = '0;
        else if (cnt_reg == '1)
            cnt_next = cnt_reg;
        else
            cnt_next = cnt_reg + CNT_W'(1);

        if (!lock_s_reg)
            stab_next = '0;
        else if (stab_reg >= STAB_MAX)
            stab_next = stab_reg;
        else
            stab_next = stab_reg + STAB_W'(1);

        // Outputs are decoded from the next state and registered with it,
        // so they change on the same edge as the state.
        pllen_next     = (state_next == S_PWRUP) || (state_next == S_WAIT_LOCK) ||
                         (state_next == S_ENABLE) || (state_next == S_RUN);
        resetn_next    = (state_next == S_WAIT_LOCK) || (state_next == S_ENABLE) ||
                         (state_next == S_RUN);
        clkout_en_next = ((state_next == S_ENABLE) || (state_next == S_RUN)) ? CLKEN_MASK : 4'b0000;
        sys_rstn_next  = (state_next == S_RUN);
        ready_next     = (state_next == S_RUN);
        fail_next      = (state_next == S_FAIL);
    end

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            lock_meta_reg <= 1'b0;
            lock_s_reg    <= 1'b0;
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            stab_reg      <= '0;
            retry_reg     <= 2'd0;
            pllen         <= 1'b0;
            resetn        <= 1'b0;
            clkout_en     <= 4'b0000;
            sys_rstn      <= 1'b0;
            ready         <= 1'b0;
            fail          <= 1'b0;
        end else begin
            lock_meta_reg <= lock;
            lock_s_reg    <= lock_meta_reg;
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            stab_reg      <= stab_next;
            retry_reg     <= retry_next;
            pllen         <= pllen_next;
            resetn        <= resetn_next;
            clkout_en     <= clkout_en_next;
            sys_rstn      <= sys_rstn_next;
            ready         <= ready_next;
            fail          <= fail_next;
        end
    end

    assign retry_cnt = retry_reg;

endmodule
